// File: rtl/pipeline_controller_pkg.sv
// Shared definitions for the pipeline hazard/forwarding controller.
// Holds register codes, jump classes, forwarding selects, FSM states and the
// scoreboard entry layout used by pipeline_controller and dest_scoreboard.
package pipeline_controller_pkg;

    // Special register codes; GPRs occupy 0-7.
    localparam logic [3:0] REG_IH = 4'd8;
    localparam logic [3:0] REG_SP = 4'd9;
    localparam logic [3:0] REG_RA = 4'd10;

    typedef enum logic [2:0] {
        JMP_IDLE = 3'd0,
        JMP_EQZ  = 3'd1,
        JMP_NEZ  = 3'd2,
        JMP_TEQZ = 3'd3,
        JMP_TNEZ = 3'd4,
        JMP_JUMP = 3'd5,
        JMP_DB   = 3'd6
    } jump_e;

    localparam logic [1:0] FWD_RF  = 2'b00;
    localparam logic [1:0] FWD_EX  = 2'b01;
    localparam logic [1:0] FWD_MEM = 2'b10;
    localparam logic [1:0] FWD_WB  = 2'b11;

    typedef enum logic [1:0] {
        ST_RUN     = 2'd0,
        ST_LDSTALL = 2'd1,
        ST_MEMWAIT = 2'd2
    } state_e;

    typedef struct packed {
        logic [3:0] dst;
        logic       wr;
        logic       load;
        logic       mem;
    } sb_entry_t;

    // Jump classes that read idRegS in ID and therefore need its value there.
    function automatic logic reads_src_in_id(input logic [2:0] j);
        return (j >= 3'(JMP_EQZ)) && (j <= 3'(JMP_JUMP));
    endfunction

endpackage

// File: rtl/dest_scoreboard.sv
// Three-stage (EX/MEM/WB) destination shift register plus source match logic.
// Ports: shift/bubble control and ID entry in; forwarding selects, load-use,
// EX-hit-on-S and the mem flags of the EX/MEM entries out. Zero latency on matches.
module dest_scoreboard
    import pipeline_controller_pkg::*;
(
    input  logic       clk,
    input  logic       rst,
    input  logic       shift_i,
    input  logic       bubble_i,
    input  sb_entry_t  id_entry_i,
    input  logic [3:0] reg_s_i,
    input  logic [3:0] reg_m_i,
    input  logic       use_s_i,
    input  logic       use_m_i,
    output logic [1:0] fwd_s_o,
    output logic [1:0] fwd_m_o,
    output logic       load_use_o,
    output logic       ex_hit_s_o,
    output logic       ex_mem_o,
    output logic       mem_mem_o
);

    sb_entry_t ex_q, mem_q, wb_q;

    // Full 4-bit compare so IH/SP/RA forward exactly like GPRs.
    function automatic logic hit(input sb_entry_t e, input logic [3:0] r);
        return e.wr && (e.dst == r);
    endfunction

    // A load in EX has no data yet, so it falls through to older stages.
    function automatic logic [1:0] fwd_sel(input logic [3:0] r, input logic u,
                                           input sb_entry_t ex, input sb_entry_t mem,
                                           input sb_entry_t wb);
        if (!u)                        return FWD_RF;
        else if (hit(ex, r) && !ex.load) return FWD_EX;
        else if (hit(mem, r))          return FWD_MEM;
        else if (hit(wb, r))           return FWD_WB;
        else                           return FWD_RF;
    endfunction

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            ex_q  <= '0;
            mem_q <= '0;
            wb_q  <= '0;
        end else if (shift_i) begin
            ex_q  <= bubble_i ? '0 : id_entry_i;
            mem_q <= ex_q;
            wb_q  <= mem_q;
        end
    end

    assign fwd_s_o    = fwd_sel(reg_s_i, use_s_i, ex_q, mem_q, wb_q);
    assign fwd_m_o    = fwd_sel(reg_m_i, use_m_i, ex_q, mem_q, wb_q);
    assign load_use_o = ex_q.load && ((use_s_i && hit(ex_q, reg_s_i)) ||
                                      (use_m_i && hit(ex_q, reg_m_i)));
    assign ex_hit_s_o = hit(ex_q, reg_s_i);
    assign ex_mem_o   = ex_q.mem;
    assign mem_mem_o  = mem_q.mem;

endmodule

// File: rtl/pipeline_controller.sv
// Pipeline hazard controller: forwarding selects, load-use/branch stalls, flushes
// and shared-memory arbitration (RUN/LDSTALL/MEMWAIT). Forwarding/stall decisions
// are combinational; memory grant and post-wait flush are registered.
module pipeline_controller
    import pipeline_controller_pkg::*;
(
    input  logic       clk,
    input  logic       rst,
    input  logic [3:0] idRegS,
    input  logic [3:0] idRegM,
    input  logic       idUseS,
    input  logic       idUseM,
    input  logic [3:0] idRegT,
    input  logic       idWrite,
    input  logic       idMemRead,
    input  logic       idMemWrite,
    input  logic [2:0] idJump,
    input  logic       idBranchTaken,
    input  logic       memReady,
    output logic       pcStall,
    output logic       ifidStall,
    output logic       ifidFlush,
    output logic       idexBubble,
    output logic       memGrantData,
    output logic [1:0] fwdS,
    output logic [1:0] fwdM
);

    state_e     state_q;
    logic       grant_q;
    logic       flush_q;
    logic       load_use, ex_hit_s, ex_mem, mem_mem;
    logic       stall;
    logic [1:0] fwd_s, fwd_m;
    sb_entry_t  id_entry;

    assign id_entry = '{dst: idRegT, wr: idWrite, load: idMemRead,
                        mem: idMemRead | idMemWrite};

    // The memory wait outranks any ID hazard.
    assign stall = !grant_q && (load_use || (reads_src_in_id(idJump) && ex_hit_s));

    // The bubble cycle still advances EX->MEM->WB; only the memory wait freezes it.
    dest_scoreboard u_sb (
        .clk        (clk),
        .rst        (rst),
        .shift_i    (!grant_q),
        .bubble_i   (stall),
        .id_entry_i (id_entry),
        .reg_s_i    (idRegS),
        .reg_m_i    (idRegM),
        .use_s_i    (idUseS),
        .use_m_i    (idUseM),
        .fwd_s_o    (fwd_s),
        .fwd_m_o    (fwd_m),
        .load_use_o (load_use),
        .ex_hit_s_o (ex_hit_s),
        .ex_mem_o   (ex_mem),
        .mem_mem_o  (mem_mem)
    );

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q <= ST_RUN;
            grant_q <= 1'b0;
            flush_q <= 1'b0;
        end else begin
            flush_q <= 1'b0;
            unique case (state_q)
                ST_RUN: begin
                    // A stalled instruction's memory access is picked up from LDSTALL.
                    if (stall) begin
                        state_q <= ST_LDSTALL;
                        grant_q <= 1'b0;
                    end else if (ex_mem) begin
                        state_q <= ST_MEMWAIT;
                        grant_q <= 1'b1;
                    end else begin
                        state_q <= ST_RUN;
                        grant_q <= 1'b0;
                    end
                end
                ST_LDSTALL: begin
                    state_q <= mem_mem ? ST_MEMWAIT : ST_RUN;
                    grant_q <= mem_mem;
                end
                ST_MEMWAIT: begin
                    // Fetch was starved during the wait, so the next IF/ID is junk.
                    if (memReady) begin
                        state_q <= ST_RUN;
                        grant_q <= 1'b0;
                        flush_q <= 1'b1;
                    end
                end
                default: begin
                    state_q <= ST_RUN;
                    grant_q <= 1'b0;
                end
            endcase
        end
    end

    // Gated by rst so every output is quiet while reset is held.
    assign memGrantData = grant_q;
    assign pcStall      = rst && (grant_q || stall);
    assign ifidStall    = rst && (grant_q || stall);
    assign idexBubble   = rst && stall;
    assign ifidFlush    = rst && !grant_q && (flush_q || (idBranchTaken && !stall));
    assign fwdS         = rst ? fwd_s : FWD_RF;
    assign fwdM         = rst ? fwd_m : FWD_RF;

endmodule

// File: tb/tb_pipeline_controller.sv
// Self-checking bench for pipeline_controller: directed scenarios plus random
// instruction streams compared each cycle against a stage-list reference model.
// Inputs change 1 time unit after posedge; outputs are sampled on negedge.
module tb_pipeline_controller;

    logic       clk = 1'b0;
    logic       rst;
    logic [3:0] idRegS, idRegM, idRegT;
    logic       idUseS, idUseM, idWrite, idMemRead, idMemWrite;
    logic [2:0] idJump;
    logic       idBranchTaken, memReady;
    logic       pcStall, ifidStall, ifidFlush, idexBubble, memGrantData;
    logic [1:0] fwdS, fwdM;

    always #5 clk = ~clk;

    pipeline_controller dut (
        .clk(clk), .rst(rst),
        .idRegS(idRegS), .idRegM(idRegM), .idUseS(idUseS), .idUseM(idUseM),
        .idRegT(idRegT), .idWrite(idWrite), .idMemRead(idMemRead), .idMemWrite(idMemWrite),
        .idJump(idJump), .idBranchTaken(idBranchTaken), .memReady(memReady),
        .pcStall(pcStall), .ifidStall(ifidStall), .ifidFlush(ifidFlush),
        .idexBubble(idexBubble), .memGrantData(memGrantData), .fwdS(fwdS), .fwdM(fwdM)
    );

    // Reference model: in-flight instructions, youngest first (EX, MEM, WB).
    typedef struct packed {
        logic [3:0] dst;
        logic       wr;
        logic       ld;
        logic       mem;
    } ins_t;

    ins_t pipe [3];
    int   mode;          // 0 flowing, 1 cycle after a stall, 2 waiting on data memory
    bit   flush_pending; // fetch was lost during a memory wait
    int   n_checks = 0;
    int   n_pass   = 0;

    task automatic check_eq(input string tag, input logic [15:0] got, input logic [15:0] exp);
        n_checks++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %h expected %h at %0t", tag, got, exp, $time);
    endtask

    function automatic logic [8:0] dut_vec();
        return {pcStall, ifidStall, ifidFlush, idexBubble, memGrantData, fwdS, fwdM};
    endfunction

    function automatic logic [1:0] m_fwd(input logic [3:0] r, input logic u);
        if (!u) return 2'd0;
        for (int k = 0; k < 3; k++)
            if (pipe[k].wr && pipe[k].dst == r && !(k == 0 && pipe[0].ld))
                return 2'(k + 1);
        return 2'd0;
    endfunction

    function automatic logic m_stall();
        logic lu, br;
        if (mode == 2) return 1'b0;
        lu = pipe[0].ld && pipe[0].wr &&
             ((idUseS && idRegS == pipe[0].dst) || (idUseM && idRegM == pipe[0].dst));
        br = (idJump >= 3'd1) && (idJump <= 3'd5) && pipe[0].wr && pipe[0].dst == idRegS;
        return lu || br;
    endfunction

    function automatic logic [8:0] m_out();
        logic st;
        st = m_stall();
        if (mode == 2)
            return {1'b1, 1'b1, 1'b0, 1'b0, 1'b1, m_fwd(idRegS, idUseS), m_fwd(idRegM, idUseM)};
        return {st, st, flush_pending || (idBranchTaken && !st), st, 1'b0,
                m_fwd(idRegS, idUseS), m_fwd(idRegM, idUseM)};
    endfunction

    task automatic m_step();
        logic st;
        ins_t old_ex, old_mem;
        st = m_stall();
        if (mode == 2) begin
            flush_pending = memReady;
            mode = memReady ? 0 : 2;
        end else begin
            old_ex  = pipe[0];
            old_mem = pipe[1];
            pipe[2] = pipe[1];
            pipe[1] = pipe[0];
            pipe[0] = st ? '0 : {idRegT, idWrite, idMemRead, idMemRead | idMemWrite};
            flush_pending = 1'b0;
            if (mode == 0) mode = st ? 1 : (old_ex.mem ? 2 : 0);
            else           mode = old_mem.mem ? 2 : 0;
        end
    endtask

    task automatic m_reset();
        for (int k = 0; k < 3; k++) pipe[k] = '0;
        mode = 0;
        flush_pending = 1'b0;
    endtask

    task automatic idle();
        idRegS = 0; idRegM = 0; idRegT = 0; idUseS = 0; idUseM = 0; idWrite = 0;
        idMemRead = 0; idMemWrite = 0; idJump = 0; idBranchTaken = 0; memReady = 0;
    endtask

    task automatic eval(input string tag);
        @(negedge clk);
        check_eq(tag, 16'(dut_vec()), 16'(m_out()));
        m_step();
    endtask

    task automatic adv();
        @(posedge clk);
        #1;
    endtask

    task automatic drain();
        idle();
        memReady = 1;
        for (int i = 0; i < 4; i++) begin eval("drain"); adv(); end
    endtask

    function automatic logic [3:0] rreg();
        int r;
        r = $urandom_range(0, 7);
        return (r >= 5) ? 4'(r + 3) : 4'(r);
    endfunction

    initial begin
        idle();
        rst = 1'b0;
        m_reset();
        #1;
        check_eq("reset_outs", 16'(dut_vec()), 16'd0);
        repeat (2) @(posedge clk);
        @(negedge clk) rst = 1'b1;
        adv();

        // EX holds a non-load write of r2; addu reads r2.
        idle(); idWrite = 1; idRegT = 2;
        eval("fwd_ex_setup"); adv();
        idle(); idUseS = 1; idRegS = 2; idWrite = 1; idRegT = 5;
        eval("fwd_ex");
        check_eq("fwd_ex_sel", 16'(fwdS), 16'd1);
        check_eq("fwd_ex_nostall", 16'(pcStall), 16'd0);
        adv();
        drain();

        // Load r3 followed by a use of r3 on the M port.
        idle(); idWrite = 1; idRegT = 3; idMemRead = 1;
        eval("ldu_setup"); adv();
        idle(); idUseM = 1; idRegM = 3;
        eval("ldu_stall");
        check_eq("ldu_stall_bits", 16'({pcStall, ifidStall, idexBubble}), 16'b111);
        adv();
        eval("ldu_after");
        check_eq("ldu_after_bits", 16'({pcStall, ifidStall, idexBubble}), 16'b000);
        check_eq("ldu_after_fwd", 16'(fwdM), 16'd2);
        adv();
        drain();

        // Store reaches MEM; memReady low for 3 cycles, then high.
        idle(); idMemWrite = 1; idRegS = 1; idUseS = 1;
        eval("st_setup"); adv();
        idle();
        eval("st_enter");
        check_eq("st_enter_grant", 16'(memGrantData), 16'd0);
        adv();
        for (int i = 0; i < 4; i++) begin
            idle(); memReady = (i == 3);
            eval("st_wait");
            check_eq("st_wait_grant", 16'({memGrantData, pcStall, idexBubble}), 16'b110);
            adv();
        end
        idle();
        eval("st_flush");
        check_eq("st_flush_bits", 16'({ifidFlush, memGrantData}), 16'b10);
        adv();
        eval("st_post");
        check_eq("st_post_flush", 16'(ifidFlush), 16'd0);
        adv();
        drain();

        // Conditional branch on r4 while EX writes r4, resolved taken.
        idle(); idWrite = 1; idRegT = 4;
        eval("br_setup"); adv();
        idle(); idJump = 1; idRegS = 4; idUseS = 1; idBranchTaken = 1;
        eval("br_stall");
        check_eq("br_stall_bits", 16'({pcStall, idexBubble, ifidFlush}), 16'b110);
        adv();
        eval("br_flush");
        check_eq("br_flush_bits", 16'({pcStall, idexBubble, ifidFlush}), 16'b001);
        adv();
        drain();

        // SP written in EX and in MEM; EX must win.
        idle(); idWrite = 1; idRegT = pipeline_controller_pkg::REG_SP;
        eval("sp_w1"); adv();
        eval("sp_w2"); adv();
        idle(); idUseS = 1; idRegS = pipeline_controller_pkg::REG_SP;
        eval("sp_use");
        check_eq("sp_fwd_ex", 16'(fwdS), 16'd1);
        adv();
        drain();

        // Reset in the middle of a memory wait.
        idle(); idMemWrite = 1;
        eval("rst_setup"); adv();
        idle();
        eval("rst_enter"); adv();
        eval("rst_wait");
        check_eq("rst_wait_grant", 16'(memGrantData), 16'd1);
        #2;
        rst = 1'b0;
        #1;
        check_eq("rst_async_outs", 16'(dut_vec()), 16'd0);
        m_reset();
        adv();
        idBranchTaken = 1; idJump = 5;
        #1;
        check_eq("rst_held_outs", 16'(dut_vec()), 16'd0);
        idle();
        @(negedge clk) rst = 1'b1;
        adv();
        eval("rst_run");
        check_eq("rst_run_bits", 16'({memGrantData, pcStall}), 16'b00);
        adv();
        eval("rst_run2");
        check_eq("rst_run2_grant", 16'(memGrantData), 16'd0);
        adv();

        // Random instruction stream against the model.
        for (int n = 0; n < 800; n++) begin
            int k;
            idle();
            idRegS = rreg(); idRegM = rreg(); idRegT = rreg();
            idUseS = 1'($urandom_range(0, 1));
            idUseM = 1'($urandom_range(0, 1));
            k = $urandom_range(0, 11);
            if (k == 0)      begin idMemRead = 1; idWrite = 1; end
            else if (k == 1) begin idMemWrite = 1; end
            else             idWrite = 1'($urandom_range(0, 1));
            if ($urandom_range(0, 3) == 0) begin
                idJump = 3'($urandom_range(1, 6));
                idBranchTaken = 1'($urandom_range(0, 1));
            end
            memReady = ($urandom_range(0, 2) == 0);
            eval("rand");
            adv();
        end

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
